slot_reel_game: RTL
===================

Name: slot_reel_game

Overview:
- Parametrised N-reel slot game controller for the board's switch/LED/7-segment top level.
- Each reel cycles hex symbols at a prescaled tick rate and is stopped independently by its stop button.
- A game FSM (IDLE/SPIN/JUDGE/RESULT) declares win or lose, keeps a saturating score and drives active-low 7-segment codes per reel.

Parameters:
- NUM_REELS, 3, number of reels/displays (1..8).
- SYMBOL_W, 4, reel value width; symbols 0..2^SYMBOL_W-1 (must be 4 for hex display).
- TICK_DIV, 500000, clk cycles per reel tick; tick pulses when prescaler == TICK_DIV-1.
- RESULT_TICKS, 8, ticks the RESULT state is held before returning to IDLE.
- SCORE_W, 8, score counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start_btn  in  1  asynchronous pushbutton/switch, active-high; rising edge starts a game
- stop_btn  in  NUM_REELS  asynchronous buttons, active-high; rising edge of bit i stops reel i
- reel_val  out  NUM_REELS*SYMBOL_W  current symbol of each reel; reel i at [i*SYMBOL_W +: SYMBOL_W]
- seg_n  out  NUM_REELS*8  per reel, bits [7:1] = segments a..g, bit 0 = DP; all active-low
- stopped  out  NUM_REELS  reel-stopped flags
- spinning  out  1  high in SPIN
- win  out  1  high in RESULT when all reels match
- lose  out  1  high in RESULT when any reel differs
- score  out  SCORE_W  win count, saturating

Behaviour:
- Reset (rst==0 at posedge clk):
  - prescaler=0, all reels=0, stopped=all 1s, state=IDLE, score=0, win=lose=spinning=0.
  - Synchronizer and edge-detect history flops cleared to 0.
- Input conditioning:
  - start_btn and each stop_btn pass through a 2-flop synchronizer, then a registered rising-edge detect.
  - A press is acted on 3 clk after the asynchronous edge.
  - A held level never retriggers.
- Prescaler:
  - Free-running 0..TICK_DIV-1 in every state.
  - tick=1 for one clk when prescaler==TICK_DIV-1, then prescaler wraps to 0.
- IDLE:
  - Reels hold their values. stopped holds all 1s.
  - start edge -> SPIN; stopped cleared to 0 in the same edge. Prescaler is not reset.
- SPIN:
  - On tick, each reel i with stopped[i]==0 increments by 1 modulo 2^SYMBOL_W (15 -> 0).
  - Stop edge on bit i sets stopped[i]=1 and freezes reel i.
  - If a stop edge and a tick coincide, the reel freezes at its pre-tick value (stop wins).
  - Stop edges on already-stopped reels are ignored. Several stop edges in one cycle are all taken.
  - start edges in SPIN are ignored.
  - When stopped becomes all 1s -> JUDGE on the next clk.
- JUDGE:
  - Single cycle. match = all reel values equal (NUM_REELS==1 always matches).
  - If match: win=1 and score += 1, saturating at 2^SCORE_W-1. Else lose=1.
  - -> RESULT.
- RESULT:
  - win/lose held. A tick counter counts RESULT_TICKS ticks.
  - On the RESULT_TICKS-th tick: win=lose=0 -> IDLE.
  - start edges are ignored in RESULT.
- spinning==1 exactly while state==SPIN.
- seg_n:
  - Combinational from reel value: hex 0..F with the standard active-low code set, e.g. 0=0000001x, 8=0000000x, F=0111000x.
  - DP bit 0 = 0 (lit) when stopped[i]==1, else 1.
- Reset mid-game: immediate return to the reset values at that clk edge; no partial score update.

Decomposition:
- Package slot_game_pkg holds:
  - the state enum (IDLE, SPIN, JUDGE, RESULT);
  - SEG_A..SEG_G bit index constants;
  - the 16-entry active-low hex segment constant array.
- One sub-module, hex_seg_enc: 4-bit value + dp_on in, 8-bit active-low segment code out. Instantiated NUM_REELS times via generate.

Test Plan (TICK_DIV=4, RESULT_TICKS=2, NUM_REELS=3):
- Reset: hold rst=0 for 3 clk.
  - reels=0, score=0, stopped=3'b111, win=lose=spinning=0.
  - seg_n per reel = 8'b00000010.
- Spin and wrap: start edge, no stops, run 17 ticks.
  - All reels step together: 0 -> 15 -> 0 -> 1.
  - reel_val=3x 4'h1.
- Win path: start, wait 5 ticks, pulse all stop bits in one cycle.
  - Reels frozen at 5, JUDGE -> win=1, score=1.
  - IDLE after 2 ticks.
- Lose path: start, stop reel 0 after 2 ticks, reel 1 after 3 ticks, reel 2 after 5 ticks.
  - Values 2,3,5; lose=1; score unchanged.
  - DP lit on each reel as it stops.
- Stop/tick collision: assert the stop_btn[1] edge so its detect pulse lands on the tick cycle.
  - Reel 1 keeps its pre-tick value.
  - Reels 0 and 2 advance.
- Saturation and mid-game reset:
  - SCORE_W=2: after 4 wins, score stays 3.
  - rst=0 during SPIN: all outputs return to reset values the next clk.

Source files
------------

// File: rtl/slot_game_pkg.sv
// Shared types and constants for the slot reel game.
// Segment codes are active-low, ordered a..g with a in bit 6.
package slot_game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SPIN,
    JUDGE,
    RESULT
  } state_t;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'b0000001,
    7'b1001111,
    7'b0010010,
    7'b0000110,
    7'b1001100,
    7'b0100100,
    7'b0100000,
    7'b0001111,
    7'b0000000,
    7'b0000100,
    7'b0001000,
    7'b1100000,
    7'b0110001,
    7'b1000010,
    7'b0110000,
    7'b0111000
  };

endpackage

// File: rtl/slot_reel_game_if.sv
// Button inputs and display/status outputs of the slot game.
// The board side is master, the game controller is slave.
interface slot_reel_game_if #(
  parameter int NUM_REELS = 3,
  parameter int SYMBOL_W  = 4,
  parameter int SCORE_W   = 8
);
  logic                          start_btn;
  logic [NUM_REELS-1:0]          stop_btn;
  logic [NUM_REELS*SYMBOL_W-1:0] reel_val;
  logic [NUM_REELS*8-1:0]        seg_n;
  logic [NUM_REELS-1:0]          stopped;
  logic                          spinning;
  logic                          win;
  logic                          lose;
  logic [SCORE_W-1:0]            score;

  modport master (
    output start_btn, stop_btn,
    input  reel_val, seg_n, stopped,
    input  spinning, win, lose, score
  );

  modport slave (
    input  start_btn, stop_btn,
    output reel_val, seg_n, stopped,
    output spinning, win, lose, score
  );
endinterface

// File: rtl/hex_seg_enc.sv
// Hex digit to active-low 7-segment code with decimal point.
// Output bits [7:1] are segments a..g, bit 0 is DP.
module hex_seg_enc
  import slot_game_pkg::*;
(
  input  logic [3:0] val,
  input  logic       dp_on,
  output logic [7:0] seg_n
);
  logic [6:0] code;

  always_comb begin
    code         = HEX_SEG[val];
    seg_n        = '1;
    seg_n[SEG_A] = code[6];
    seg_n[SEG_B] = code[5];
    seg_n[SEG_C] = code[4];
    seg_n[SEG_D] = code[3];
    seg_n[SEG_E] = code[2];
    seg_n[SEG_F] = code[1];
    seg_n[SEG_G] = code[0];
    seg_n[SEG_DP] = ~dp_on;
  end
endmodule

// File: rtl/slot_reel_game.sv
// N-reel slot game: synchronised buttons, tick prescaler,
// reel counters and IDLE/SPIN/JUDGE/RESULT game FSM.
module slot_reel_game
  import slot_game_pkg::*;
#(
  parameter int NUM_REELS    = 3,
  parameter int SYMBOL_W     = 4,
  parameter int TICK_DIV     = 500000,
  parameter int RESULT_TICKS = 8,
  parameter int SCORE_W      = 8
) (
  input  logic clk,
  input  logic rst,
  slot_reel_game_if.slave io
);
  localparam int BW = NUM_REELS + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(RESULT_TICKS + 1);

  logic [BW-1:0]        s1, s2, s3;
  logic [BW-1:0]        btn_edge;
  logic [PW-1:0]        presc;
  logic                 tick;
  logic [SYMBOL_W-1:0]  reel [NUM_REELS];
  logic [NUM_REELS-1:0] stopped;
  logic [NUM_REELS-1:0] stop_hit;
  logic [RW-1:0]        rcnt;
  logic [SCORE_W-1:0]   score;
  logic                 win, lose, spinning;
  logic                 match;
  state_t               state;

  // bit 0 is start, bits NUM_REELS:1 are the stop buttons
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {io.stop_btn, io.start_btn};
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign btn_edge = s2 & ~s3;
  assign stop_hit = btn_edge[NUM_REELS:1] & ~stopped;
  assign tick     = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) presc <= '0;
    else      presc <= tick ? '0 : presc + 1'b1;
  end

  always_comb begin
    match = 1'b1;
    for (int i = 1; i < NUM_REELS; i++)
      if (reel[i] != reel[0]) match = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      stopped  <= '1;
      spinning <= 1'b0;
      win      <= 1'b0;
      lose     <= 1'b0;
      score    <= '0;
      rcnt     <= '0;
      for (int i = 0; i < NUM_REELS; i++)
        reel[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (btn_edge[0]) begin
            state    <= SPIN;
            stopped  <= '0;
            spinning <= 1'b1;
          end
        end
        SPIN: begin
          // a stop landing on a tick freezes the pre-tick symbol
          for (int i = 0; i < NUM_REELS; i++)
            if (tick && !stopped[i] && !stop_hit[i])
              reel[i] <= reel[i] + 1'b1;
          stopped <= stopped | stop_hit;
          if (&stopped) begin
            state    <= JUDGE;
            spinning <= 1'b0;
          end
        end
        JUDGE: begin
          if (match) begin
            win <= 1'b1;
            if (score != '1) score <= score + 1'b1;
          end else begin
            lose <= 1'b1;
          end
          rcnt  <= '0;
          state <= RESULT;
        end
        RESULT: begin
          if (tick) begin
            if (rcnt == RW'(RESULT_TICKS - 1)) begin
              win   <= 1'b0;
              lose  <= 1'b0;
              state <= IDLE;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
    assign io.reel_val[i*SYMBOL_W +: SYMBOL_W] = reel[i];
    hex_seg_enc u_enc (
      .val   (reel[i]),
      .dp_on (stopped[i]),
      .seg_n (io.seg_n[i*8 +: 8])
    );
  end

  assign io.stopped  = stopped;
  assign io.spinning = spinning;
  assign io.win      = win;
  assign io.lose     = lose;
  assign io.score    = score;
endmodule
